ro_puf_measure_sequencer: RTL and testbench

Sequences challenge-response evaluation for the ring-oscillator PUF array. For each response bit it selects an RO pair, clears the pair's frequency counters, enables them for a fixed measurement window, waits for the counts to settle, and compares the two counts. The collected response word is presented through a valid/ready handshake. It sits between the challenge interface and the RO mux plus the two edge counters.

---
 rtl/ro_puf_measure_sequencer.sv | 208 ++++++++++++++++++++
 tb/tb_ro_puf_measure_sequencer.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ro_puf_measure_sequencer.sv
// Challenge-response sequencer for the ring-oscillator PUF: for each response bit it
// clears, gates and compares one RO pair's edge counters, then hands the word out.
module ro_puf_measure_sequencer #(
    parameter int NUM_RO    = 16,
    parameter int SEL_W     = 4,
    parameter int CNT_W     = 16,
    parameter int RESP_BITS = 8,
    parameter int WINDOW    = 1024,
    parameter int SETTLE    = 4,
    parameter int TMR_W     = 16
) (
    input  logic                           gated_clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           abort,
    input  logic [RESP_BITS*2*SEL_W-1:0]   challenge,
    input  logic [CNT_W-1:0]               count_a,
    input  logic [CNT_W-1:0]               count_b,
    output logic [SEL_W-1:0]               sel_a,
    output logic [SEL_W-1:0]               sel_b,
    output logic                           cnt_reset,
    output logic                           cnt_enable,
    output logic                           busy,
    output logic [RESP_BITS-1:0]           response,
    output logic [RESP_BITS-1:0]           tie_flags,
    output logic                           err,
    output logic                           resp_valid,
    input  logic                           resp_ready
);

    localparam int PAIR_W = 2 * SEL_W;
    localparam int BIDX_W = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;

    localparam logic [BIDX_W-1:0] BIDX_LAST   = BIDX_W'(RESP_BITS - 1);
    localparam logic [BIDX_W-1:0] BIDX_ONE    = BIDX_W'(1);
    localparam logic [TMR_W-1:0]  WIN_LAST    = TMR_W'(WINDOW - 1);
    localparam logic [TMR_W-1:0]  SETTLE_LAST = TMR_W'(SETTLE - 1);
    localparam logic [TMR_W-1:0]  TMR_ONE     = TMR_W'(1);

    if (NUM_RO > (1 << SEL_W)) begin : g_sel_too_narrow
        $error("SEL_W cannot address NUM_RO oscillators");
    end
    if (WINDOW < 1 || SETTLE < 1 || WINDOW > (1 << TMR_W) || SETTLE > (1 << TMR_W)) begin : g_bad_timer
        $error("WINDOW/SETTLE must be >= 1 and fit in TMR_W");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_MEASURE,
        ST_SETTLE,
        ST_COMPARE,
        ST_DONE
    } state_t;

    state_t                      state, state_next;
    logic [TMR_W-1:0]            timer, timer_next;
    logic [BIDX_W-1:0]           bit_idx, bit_idx_next;
    logic [RESP_BITS*PAIR_W-1:0] chal_q;
    logic                        chal_load;

    logic [SEL_W-1:0]            sel_a_next, sel_b_next;
    logic                        cnt_reset_next, cnt_enable_next, busy_next;
    logic [RESP_BITS-1:0]        response_next, tie_flags_next;
    logic                        err_next, resp_valid_next;

    logic                        cmp_gt, cmp_eq, cmp_same;

    function automatic logic [PAIR_W-1:0] pair_of(input logic [RESP_BITS*PAIR_W-1:0] chal,
                                                  input logic [BIDX_W-1:0] idx);
        return chal[int'(idx)*PAIR_W +: PAIR_W];
    endfunction

    assign cmp_gt   = (count_a > count_b);
    assign cmp_eq   = (count_a == count_b);
    assign cmp_same = (sel_a == sel_b);

    always_comb begin
        state_next      = state;
        timer_next      = timer;
        bit_idx_next    = bit_idx;
        chal_load       = 1'b0;
        sel_a_next      = sel_a;
        sel_b_next      = sel_b;
        cnt_reset_next  = 1'b0;
        cnt_enable_next = 1'b0;
        busy_next       = 1'b0;
        response_next   = response;
        tie_flags_next  = tie_flags;
        err_next        = err;
        resp_valid_next = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    // The challenge register loads on this same edge, so select from the port.
                    state_next               = ST_CLEAR;
                    chal_load                = 1'b1;
                    bit_idx_next             = '0;
                    response_next            = '0;
                    tie_flags_next           = '0;
                    err_next                 = 1'b0;
                    {sel_a_next, sel_b_next} = pair_of(challenge, '0);
                    cnt_reset_next           = 1'b1;
                    busy_next                = 1'b1;
                end
            end
            ST_CLEAR: begin
                state_next      = ST_MEASURE;
                timer_next      = '0;
                cnt_enable_next = 1'b1;
                busy_next       = 1'b1;
            end
            ST_MEASURE: begin
                busy_next = 1'b1;
                if (timer == WIN_LAST) begin
                    state_next = ST_SETTLE;
                    timer_next = '0;
                end else begin
                    timer_next      = timer + TMR_ONE;
                    cnt_enable_next = 1'b1;
                end
            end
            ST_SETTLE: begin
                busy_next = 1'b1;
                if (timer == SETTLE_LAST) begin
                    state_next = ST_COMPARE;
                end else begin
                    timer_next = timer + TMR_ONE;
                end
            end
            ST_COMPARE: begin
                // A pair that selects the same RO cannot produce a meaningful bit.
                response_next[bit_idx]  = cmp_gt && !cmp_same;
                tie_flags_next[bit_idx] = cmp_eq;
                err_next                = err | cmp_same;
                if (bit_idx == BIDX_LAST) begin
                    state_next      = ST_DONE;
                    resp_valid_next = 1'b1;
                end else begin
                    state_next               = ST_CLEAR;
                    bit_idx_next             = bit_idx + BIDX_ONE;
                    {sel_a_next, sel_b_next} = pair_of(chal_q, bit_idx + BIDX_ONE);
                    cnt_reset_next           = 1'b1;
                    busy_next                = 1'b1;
                end
            end
            ST_DONE: begin
                if (resp_ready) begin
                    state_next = ST_IDLE;
                end else begin
                    resp_valid_next = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        if (abort && (state inside {ST_CLEAR, ST_MEASURE, ST_SETTLE, ST_COMPARE})) begin
            state_next      = ST_IDLE;
            timer_next      = '0;
            bit_idx_next    = '0;
            cnt_reset_next  = 1'b0;
            cnt_enable_next = 1'b0;
            busy_next       = 1'b0;
            response_next   = '0;
            tie_flags_next  = '0;
            err_next        = 1'b0;
            resp_valid_next = 1'b0;
        end
    end

    always_ff @(posedge gated_clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            timer      <= '0;
            bit_idx    <= '0;
            sel_a      <= '0;
            sel_b      <= '0;
            cnt_reset  <= 1'b0;
            cnt_enable <= 1'b0;
            busy       <= 1'b0;
            response   <= '0;
            tie_flags  <= '0;
            err        <= 1'b0;
            resp_valid <= 1'b0;
        end else begin
            state      <= state_next;
            timer      <= timer_next;
            bit_idx    <= bit_idx_next;
            sel_a      <= sel_a_next;
            sel_b      <= sel_b_next;
            cnt_reset  <= cnt_reset_next;
            cnt_enable <= cnt_enable_next;
            busy       <= busy_next;
            response   <= response_next;
            tie_flags  <= tie_flags_next;
            err        <= err_next;
            resp_valid <= resp_valid_next;
        end
    end

    always_ff @(posedge gated_clk) begin
        if (chal_load) begin
            chal_q <= challenge;
        end
    end

endmodule

// File: tb/tb_ro_puf_measure_sequencer.sv
// Bench for ro_puf_measure_sequencer: behavioural RO counters on the count inputs and a
// rate-times-window reference model for the response word, tie flags and error flag.
module tb_ro_puf_measure_sequencer;

    localparam int NUM_RO = 16;
    localparam int SEL_W  = 4;
    localparam int CNT_W  = 16;
    localparam int RB     = 4;
    localparam int WINDOW = 8;
    localparam int SETTLE = 2;
    localparam int TMR_W  = 16;
    localparam int PAIR_W = 2 * SEL_W;
    localparam int CHW    = RB * PAIR_W;
    localparam int LAT    = RB * (WINDOW + SETTLE + 2) + 1;
    localparam logic [CHW-1:0] BASIC_CHAL = 32'h6754_2310;

    logic             gated_clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic             resp_ready = 1'b0;
    logic [CHW-1:0]   challenge = '0;
    logic [CNT_W-1:0] count_a = '0;
    logic [CNT_W-1:0] count_b = '0;
    logic [SEL_W-1:0] sel_a, sel_b;
    logic             cnt_reset, cnt_enable, busy, err, resp_valid;
    logic [RB-1:0]    response, tie_flags;

    logic [CNT_W-1:0] rate [NUM_RO];
    int n_checks = 0;
    int n_fail   = 0;

    ro_puf_measure_sequencer #(
        .NUM_RO(NUM_RO), .SEL_W(SEL_W), .CNT_W(CNT_W), .RESP_BITS(RB),
        .WINDOW(WINDOW), .SETTLE(SETTLE), .TMR_W(TMR_W)
    ) dut (
        .gated_clk(gated_clk), .reset(reset), .start(start), .abort(abort),
        .challenge(challenge), .count_a(count_a), .count_b(count_b),
        .sel_a(sel_a), .sel_b(sel_b), .cnt_reset(cnt_reset), .cnt_enable(cnt_enable),
        .busy(busy), .response(response), .tie_flags(tie_flags), .err(err),
        .resp_valid(resp_valid), .resp_ready(resp_ready)
    );

    always #5 gated_clk = ~gated_clk;

    // Edge counters on the selected oscillators: each RO adds its rate per enabled cycle.
    always @(posedge gated_clk) begin
        if (cnt_reset) begin
            count_a <= '0;
            count_b <= '0;
        end else if (cnt_enable) begin
            count_a <= count_a + rate[sel_a];
            count_b <= count_b + rate[sel_b];
        end
    end

    task automatic tick;
        @(posedge gated_clk);
        #1;
    endtask

    function automatic void model(input logic [CHW-1:0] c, output logic [RB-1:0] r,
                                  output logic [RB-1:0] t, output logic e);
        int a, b, ca, cb;
        r = '0;
        t = '0;
        e = 1'b0;
        for (int i = 0; i < RB; i++) begin
            a  = int'(c[i*PAIR_W+SEL_W +: SEL_W]);
            b  = int'(c[i*PAIR_W +: SEL_W]);
            ca = int'(rate[a]) * WINDOW;
            cb = int'(rate[b]) * WINDOW;
            t[i] = (ca == cb);
            r[i] = (a != b) && (ca > cb);
            if (a == b) e = 1'b1;
        end
    endfunction

    task automatic random_rates(input int hi);
        for (int i = 0; i < NUM_RO; i++) rate[i] = CNT_W'($urandom_range(1, hi));
    endtask

    task automatic basic_rates;
        random_rates(30);
        rate[1] = rate[0] + CNT_W'($urandom_range(1, 10));
        rate[3] = rate[2] + CNT_W'($urandom_range(1, 10));
        rate[5] = rate[4] + CNT_W'($urandom_range(1, 10));
        rate[7] = rate[6] + CNT_W'($urandom_range(1, 10));
    endtask

    // Starts one evaluation and records what the counter-facing outputs did until resp_valid.
    task automatic run_eval(input logic [CHW-1:0] chal, output int lat, output int n_rst,
                            output int n_runs, output int bad_runs, output int bad_sel);
        int run_len;
        logic [SEL_W-1:0] pa, pb;
        n_rst = 0; n_runs = 0; bad_runs = 0; bad_sel = 0; run_len = 0;
        challenge = chal;
        start = 1'b1;
        tick;
        start = 1'b0;
        lat = 1;
        pa = sel_a;
        pb = sel_b;
        forever begin
            if (cnt_reset) begin
                if (n_rst >= RB) bad_sel++;
                else if ({sel_a, sel_b} !== chal[n_rst*PAIR_W +: PAIR_W]) bad_sel++;
                n_rst++;
            end else if (sel_a !== pa || sel_b !== pb) begin
                bad_sel++;
            end
            pa = sel_a;
            pb = sel_b;
            if (cnt_enable) run_len++;
            else if (run_len != 0) begin
                n_runs++;
                if (run_len != WINDOW) bad_runs++;
                run_len = 0;
            end
            if (resp_valid || lat >= 4 * LAT) break;
            tick;
            lat++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({sel_a, sel_b, cnt_reset, cnt_enable, busy, response, tie_flags, err, resp_valid} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got sel=%h/%h rst=%b en=%b busy=%b resp=%h tie=%h err=%b vld=%b, expected all 0",
                     sel_a, sel_b, cnt_reset, cnt_enable, busy, response, tie_flags, err, resp_valid);
        end
        #10 reset = 1'b0;
        tick;
        tick;
        n_checks++;
        if ({busy, resp_valid, cnt_enable} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_idle: got busy/vld/en=%b expected 000", {busy, resp_valid, cnt_enable});
        end
    endtask

    task automatic test_basic;
        int lat, n_rst, n_runs, bad_runs, bad_sel;
        logic [RB-1:0] r, t;
        logic e;
        basic_rates;
        model(BASIC_CHAL, r, t, e);
        resp_ready = 1'b0;
        run_eval(BASIC_CHAL, lat, n_rst, n_runs, bad_runs, bad_sel);
        n_checks++;
        if (lat !== LAT) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d cycles expected %0d", lat, LAT);
        end
        n_checks++;
        if ({response, tie_flags, err} !== {4'b0101, 4'b0000, 1'b0} || response !== r) begin
            n_fail++;
            $display("FAIL basic_result: got resp=%b tie=%b err=%b expected resp=0101 tie=0000 err=0",
                     response, tie_flags, err);
        end
        n_checks++;
        if (n_rst !== RB || n_runs !== RB || bad_runs !== 0 || bad_sel !== 0) begin
            n_fail++;
            $display("FAIL basic_window: got clears=%0d windows=%0d bad_windows=%0d bad_sel=%0d expected %0d %0d 0 0",
                     n_rst, n_runs, bad_runs, bad_sel, RB, RB);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_busy_done: got %b expected 0", busy);
        end
        resp_ready = 1'b1;
        tick;
        resp_ready = 1'b0;
        n_checks++;
        if (resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_handshake: got resp_valid=%b expected 0", resp_valid);
        end
    endtask

    task automatic test_random;
        int lat, n_rst, n_runs, bad_runs, bad_sel, k;
        logic [CHW-1:0] chal;
        logic [RB-1:0] r, t;
        logic e;
        resp_ready = 1'b1;
        for (int it = 0; it < 6; it++) begin
            random_rates(6);
            chal = CHW'($urandom);
            if (it % 3 == 0) begin
                k = $urandom_range(0, RB - 1);
                chal[k*PAIR_W+SEL_W +: SEL_W] = chal[k*PAIR_W +: SEL_W];
            end
            model(chal, r, t, e);
            run_eval(chal, lat, n_rst, n_runs, bad_runs, bad_sel);
            n_checks++;
            if ({response, tie_flags, err} !== {r, t, e} || lat !== LAT) begin
                n_fail++;
                $display("FAIL random_%0d: got resp=%b tie=%b err=%b lat=%0d expected resp=%b tie=%b err=%b lat=%0d",
                         it, response, tie_flags, err, lat, r, t, e, LAT);
            end
            n_checks++;
            if (bad_sel !== 0 || bad_runs !== 0) begin
                n_fail++;
                $display("FAIL random_timing_%0d: got bad_sel=%0d bad_windows=%0d expected 0 0", it, bad_sel, bad_runs);
            end
            tick;
            n_checks++;
            if (resp_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL random_ready_high_%0d: got resp_valid=%b expected 0", it, resp_valid);
            end
        end
        resp_ready = 1'b0;
    endtask

    task automatic test_tie_err;
        int lat, n_rst, n_runs, bad_runs, bad_sel;
        logic [CHW-1:0] chal;
        logic [RB-1:0] r, t;
        logic e;
        random_rates(30);
        rate[9] = rate[2];
        chal = {8'h81, 8'h45, 8'h33, 8'h29};
        model(chal, r, t, e);
        run_eval(chal, lat, n_rst, n_runs, bad_runs, bad_sel);
        n_checks++;
        if (response[1:0] !== 2'b00 || tie_flags[0] !== 1'b1 || err !== 1'b1) begin
            n_fail++;
            $display("FAIL tie_err_bits: got resp[1:0]=%b tie[0]=%b err=%b expected 00 1 1",
                     response[1:0], tie_flags[0], err);
        end
        n_checks++;
        if ({response, tie_flags, err} !== {r, t, e}) begin
            n_fail++;
            $display("FAIL tie_err_word: got resp=%b tie=%b err=%b expected resp=%b tie=%b err=%b",
                     response, tie_flags, err, r, t, e);
        end
        resp_ready = 1'b1;
        tick;
        resp_ready = 1'b0;
    endtask

    task automatic test_backpressure;
        int lat, n_rst, n_runs, bad_runs, bad_sel, unstable;
        logic [CHW-1:0] chal;
        logic [RB-1:0] r, t;
        logic e;
        random_rates(30);
        chal = CHW'($urandom);
        model(chal, r, t, e);
        run_eval(chal, lat, n_rst, n_runs, bad_runs, bad_sel);
        unstable = 0;
        for (int c = 0; c < 10; c++) begin
            if (c == 4) begin
                challenge = ~chal;
                start = 1'b1;
            end
            tick;
            start = 1'b0;
            if (resp_valid !== 1'b1 || busy !== 1'b0 || cnt_reset !== 1'b0 ||
                {response, tie_flags, err} !== {r, t, e}) unstable++;
        end
        n_checks++;
        if (unstable !== 0) begin
            n_fail++;
            $display("FAIL backpressure_hold: got %0d unstable cycles expected 0", unstable);
        end
        resp_ready = 1'b1;
        tick;
        resp_ready = 1'b0;
        n_checks++;
        if (resp_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL backpressure_release: got vld=%b busy=%b expected 0 0", resp_valid, busy);
        end
        random_rates(30);
        chal = CHW'($urandom);
        model(chal, r, t, e);
        run_eval(chal, lat, n_rst, n_runs, bad_runs, bad_sel);
        n_checks++;
        if ({response, tie_flags, err} !== {r, t, e} || lat !== LAT) begin
            n_fail++;
            $display("FAIL backpressure_next: got resp=%b tie=%b err=%b lat=%0d expected resp=%b tie=%b err=%b lat=%0d",
                     response, tie_flags, err, lat, r, t, e, LAT);
        end
        resp_ready = 1'b1;
        tick;
        resp_ready = 1'b0;
    endtask

    task automatic test_abort;
        int lat, n_rst, n_runs, bad_runs, bad_sel, nrst, en, bad;
        bit found;
        basic_rates;
        challenge = BASIC_CHAL;
        start = 1'b1;
        tick;
        start = 1'b0;
        nrst = 0; en = 0; found = 0;
        for (int c = 0; c < 4 * LAT; c++) begin
            if (cnt_reset) begin
                nrst++;
                en = 0;
            end
            if (cnt_enable) en++;
            if (nrst == 3 && en == 3) begin
                found = 1;
                break;
            end
            tick;
        end
        n_checks++;
        if (found !== 1'b1 || response !== 4'b0001) begin
            n_fail++;
            $display("FAIL abort_reach_bit2: got found=%b resp=%b expected 1 0001", found, response);
        end
        abort = 1'b1;
        tick;
        abort = 1'b0;
        n_checks++;
        if ({cnt_enable, cnt_reset, busy, resp_valid, response, tie_flags, err} !== '0) begin
            n_fail++;
            $display("FAIL abort_next_cycle: got en=%b rst=%b busy=%b vld=%b resp=%b tie=%b err=%b expected all 0",
                     cnt_enable, cnt_reset, busy, resp_valid, response, tie_flags, err);
        end
        bad = 0;
        for (int c = 0; c < 2 * LAT; c++) begin
            tick;
            if (resp_valid || busy || cnt_enable) bad++;
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL abort_stays_idle: got %0d active cycles expected 0", bad);
        end
        run_eval(BASIC_CHAL, lat, n_rst, n_runs, bad_runs, bad_sel);
        n_checks++;
        if (response !== 4'b0101 || lat !== LAT || n_rst !== RB) begin
            n_fail++;
            $display("FAIL abort_restart: got resp=%b lat=%0d clears=%0d expected 0101 %0d %0d",
                     response, lat, n_rst, LAT, RB);
        end
        resp_ready = 1'b1;
        tick;
        resp_ready = 1'b0;
    endtask

    task automatic test_reset_mid_settle;
        int lat, n_rst, n_runs, bad_runs, bad_sel, falls;
        bit prev_en, found;
        basic_rates;
        challenge = BASIC_CHAL;
        start = 1'b1;
        tick;
        start = 1'b0;
        falls = 0; prev_en = 0; found = 0;
        for (int c = 0; c < 4 * LAT; c++) begin
            if (prev_en && !cnt_enable) falls++;
            prev_en = cnt_enable;
            if (falls == 2) begin
                found = 1;
                break;
            end
            tick;
        end
        n_checks++;
        if (found !== 1'b1 || busy !== 1'b1 || response !== 4'b0001) begin
            n_fail++;
            $display("FAIL rst_reach_settle: got found=%b busy=%b resp=%b expected 1 1 0001", found, busy, response);
        end
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({sel_a, sel_b, cnt_reset, cnt_enable, busy, response, tie_flags, err, resp_valid} !== '0) begin
            n_fail++;
            $display("FAIL rst_async_outputs: got sel=%h/%h rst=%b en=%b busy=%b resp=%b tie=%b err=%b vld=%b expected all 0",
                     sel_a, sel_b, cnt_reset, cnt_enable, busy, response, tie_flags, err, resp_valid);
        end
        #13 reset = 1'b0;
        tick;
        run_eval(BASIC_CHAL, lat, n_rst, n_runs, bad_runs, bad_sel);
        n_checks++;
        if (response !== 4'b0101 || lat !== LAT || n_rst !== RB || bad_sel !== 0 || bad_runs !== 0) begin
            n_fail++;
            $display("FAIL rst_full_rerun: got resp=%b lat=%0d clears=%0d bad_sel=%0d bad_windows=%0d expected 0101 %0d %0d 0 0",
                     response, lat, n_rst, bad_sel, bad_runs, LAT, RB);
        end
        resp_ready = 1'b1;
        tick;
        resp_ready = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < NUM_RO; i++) rate[i] = '0;
        test_reset;
        test_basic;
        test_random;
        test_tie_err;
        test_backpressure;
        test_abort;
        test_reset_mid_settle;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached before the sequence completed");
        $fatal(1, "watchdog expired");
    end

endmodule
